// File: rtl/mux32_rr_collector_if.sv
// mux32_rr_collector_if: 32-channel request side plus registered upstream stream.
// master = collector, slave = channel/upstream side.
interface mux32_rr_collector_if #(
    parameter int N = 16
);
    logic [31:0]      req_in;
    logic [32*N-1:0]  data_in;
    logic [31:0]      ack_out;
    logic [N-1:0]     data_out;
    logic [4:0]       sel_out;
    logic             valid_out;
    logic             ready_in;
    logic             timeout_out;

    modport master (
        input  req_in, data_in, ready_in,
        output ack_out, data_out, sel_out, valid_out, timeout_out
    );

    modport slave (
        output req_in, data_in, ready_in,
        input  ack_out, data_out, sel_out, valid_out, timeout_out
    );
endinterface

// File: rtl/mux32_rr_collector.sv
// mux32_rr_collector: 32-to-1 round-robin return-path collector, registered valid/ready.
// Optional stall timeout that drops a held word: define MUX_TIMEOUT_EN.
module mux32_rr_collector #(
    parameter int           N              = 16,
    parameter logic [N-1:0] DEF_VALUE      = '0,
    parameter int           TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mux32_rr_collector_if.master  bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic [4:0]   sel_q, sel_d;
    logic         valid_q, valid_d;
    logic [31:0]  ack_q, ack_d;
    logic [4:0]   last_q, last_d;

    logic [31:0]  eff_req;
    logic [4:0]   win, idx;
    logic         any;
    logic         capture;

    // Masking the channel being acked avoids re-granting its stale request.
    assign eff_req = bus.req_in & ~ack_q;

    always_comb begin
        win = last_q;
        idx = '0;
        any = 1'b0;
        for (int i = 32; i >= 1; i--) begin
            idx = last_q + 5'(i);
            if (eff_req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

`ifdef MUX_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ack_d   = '0;
        last_d  = last_q;
        capture = 1'b0;
`ifdef MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                capture = any;
            end
            HOLD: begin
                if (valid_q && bus.ready_in) begin
                    if (any) begin
                        capture = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
`ifdef MUX_TIMEOUT_EN
                    cnt_d = '0;
                end else if (valid_q) begin
                    if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        valid_d = 1'b0;
                        to_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            data_d  = bus.data_in[win*N +: N];
            sel_d   = win;
            valid_d = 1'b1;
            ack_d   = 32'd1 << win;
            last_d  = win;
            state_d = HOLD;
`ifdef MUX_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= DEF_VALUE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            last_q  <= 5'd31;
`ifdef MUX_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
`ifdef MUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.sel_out   = sel_q;
    assign bus.valid_out = valid_q;
    assign bus.ack_out   = ack_q;
`ifdef MUX_TIMEOUT_EN
    assign bus.timeout_out = to_q;
`else
    assign bus.timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_mux32_rr_collector.sv
// tb_mux32_rr_collector: scoreboard bench for the 32-to-1 round-robin collector.
// Channels drop req right after their ack pulse; accepted words are popped and compared.
module tb_mux32_rr_collector;

    localparam int N = 16;
`ifdef MUX_TIMEOUT_EN
    localparam int STALL = 2;
`else
    localparam int STALL = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mux32_rr_collector_if #(.N(N)) bus ();

    mux32_rr_collector #(
        .N(N),
        .DEF_VALUE('0),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [N-1:0] v);
        bus.data_in[k*N +: N] = v;
    endtask

    task automatic push(input int k);
        sb.push_back({11'd0, 5'(k), bus.data_in[k*N +: N]});
    endtask

    task automatic step();
        logic        fire;
        logic [31:0] got;
        logic [31:0] exp;
        fire = bus.valid_out && bus.ready_in && !rst;
        got  = {11'd0, bus.sel_out, bus.data_out};
        @(posedge clk);
        #1;
        if (fire) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", got, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                check("sb_word", got, exp);
            end
        end
        check("ack_onehot", 32'($onehot0(bus.ack_out)), 32'd1);
        bus.req_in = bus.req_in & ~bus.ack_out;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    int n;

    initial begin
        bus.req_in   = '0;
        bus.data_in  = '0;
        bus.ready_in = 1'b0;

        // 1: reset state and single request latency
        rst = 1'b1;
        step();
        step();
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_sel", 32'(bus.sel_out), 32'd0);
        check("rst_ack", bus.ack_out, 32'd0);
        check("rst_timeout", 32'(bus.timeout_out), 32'd0);
        rst = 1'b0;
        set_word(0, 16'hA5A5);
        bus.req_in   = 32'h0000_0001;
        bus.ready_in = 1'b1;
        push(0);
        step();
        check("t1_valid", 32'(bus.valid_out), 32'd1);
        check("t1_data", 32'(bus.data_out), 32'h0000_A5A5);
        check("t1_sel", 32'(bus.sel_out), 32'd0);
        check("t1_ack", bus.ack_out, 32'h0000_0001);
        step();
        check("t1_ack_gone", bus.ack_out, 32'd0);
        check("t1_idle", 32'(bus.valid_out), 32'd0);
        check("t1_sb", 32'(sb.size()), 32'd0);

        // 2: all channels requesting, back-to-back 0..31
        do_reset();
        for (int k = 0; k < 32; k++) begin
            set_word(k, 16'(k * 16'h0101) ^ 16'h5A00);
            push(k);
        end
        bus.req_in = 32'hFFFF_FFFF;
        drain(40, n);
        check("t2_cycles", 32'(n), 32'd33);
        check("t2_req_all_acked", bus.req_in, 32'd0);

        // 3: wrap order from last_grant=5
        do_reset();
        set_word(5, 16'h0505);
        bus.req_in = 32'h0000_0020;
        push(5);
        drain(5, n);
        step();
        set_word(3, 16'h0303);
        set_word(9, 16'h0909);
        bus.req_in = 32'h0000_0208;
        push(9);
        push(3);
        step();
        check("t3_first_ack", bus.ack_out, 32'h0000_0200);
        drain(5, n);

        // 4: stall with a competing requester
        step();
        bus.ready_in = 1'b0;
        set_word(7, 16'h1234);
        bus.req_in = 32'h0000_0080;
        push(7);
        step();
        set_word(8, 16'h5678);
        bus.req_in = bus.req_in | 32'h0000_0100;
        push(8);
        for (int i = 0; i < STALL; i++) begin
            step();
            check("t4_data", 32'(bus.data_out), 32'h0000_1234);
            check("t4_sel", 32'(bus.sel_out), 32'd7);
            check("t4_valid", 32'(bus.valid_out), 32'd1);
            check("t4_no_ack", bus.ack_out, 32'd0);
        end
        bus.ready_in = 1'b1;
        step();
        check("t4_ack8", bus.ack_out, 32'h0000_0100);
        check("t4_sel8", 32'(bus.sel_out), 32'd8);
        drain(5, n);

        // 5: reset while holding a word
        step();
        bus.ready_in = 1'b0;
        set_word(2, 16'h2222);
        bus.req_in = 32'h0000_0004;
        step();
        check("t5_hold", 32'(bus.valid_out), 32'd1);
        do_reset();
        check("t5_valid", 32'(bus.valid_out), 32'd0);
        check("t5_data", 32'(bus.data_out), 32'd0);
        check("t5_sel", 32'(bus.sel_out), 32'd0);
        check("t5_ack", bus.ack_out, 32'd0);
        set_word(0, 16'h0F0F);
        set_word(4, 16'h4444);
        bus.req_in   = 32'h0000_0011;
        bus.ready_in = 1'b1;
        push(0);
        push(4);
        step();
        check("t5_first_ch0", 32'(bus.sel_out), 32'd0);
        drain(5, n);

        // 6: stall timeout behaviour
        step();
        bus.ready_in = 1'b0;
        set_word(10, 16'hABCD);
        bus.req_in = 32'h0000_0400;
        push(10);
        step();
`ifdef MUX_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_valid_held", 32'(bus.valid_out), 32'd1);
            check("t6_no_timeout", 32'(bus.timeout_out), 32'd0);
        end
        step();
        check("t6_dropped", 32'(bus.valid_out), 32'd0);
        check("t6_timeout", 32'(bus.timeout_out), 32'd1);
        step();
        check("t6_timeout_pulse", 32'(bus.timeout_out), 32'd0);
        sb.delete();
`else
        for (int i = 0; i < 8; i++) begin
            step();
            check("t6_valid_held", 32'(bus.valid_out), 32'd1);
            check("t6_no_timeout", 32'(bus.timeout_out), 32'd0);
        end
        bus.ready_in = 1'b1;
        drain(5, n);
`endif
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux32_rr_collector.md
Name: mux32_rr_collector

Overview:
- 32-to-1 return-path collector: gathers N-bit words from 32 per-bus channels into one upstream stream.
- Counterpart of the 1-to-32 fan-out demultiplexer; it sits on the bus-to-host side of the hub.
- Round-robin arbitration across channels, with a one-cycle ack pulse back to the winning channel.
- Output uses a registered valid/ready handshake.

Parameters:
- N, 16, data word width per channel.
- DEF_VALUE, {N{1'b0}}, value driven on data_out at reset.
- TIMEOUT_CYCLES, 255, stall limit used only when MUX_TIMEOUT_EN is defined (range 1..65535).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  32  per-channel request; bit k high means channel k holds a word.
- data_in  input  32*N  packed channel data; channel k occupies bits [k*N +: N]; must be stable while req_in[k] is high.
- ack_out  output  32  one-hot, one-cycle pulse to the channel whose word was captured.
- data_out  output  N  captured word.
- sel_out  output  5  index of the channel that supplied data_out.
- valid_out  output  1  data_out/sel_out valid.
- ready_in  input  1  upstream accepts when valid_out && ready_in at a clock edge.
- timeout_out  output  1  one-cycle pulse when a word is dropped; constant 0 without MUX_TIMEOUT_EN.

Behaviour:
- Reset (rst high at edge):
  - data_out=DEF_VALUE, sel_out=0, valid_out=0, ack_out=0, timeout_out=0.
  - last_grant=31, so channel 0 has first priority; state=IDLE; stall counter=0.
  - Reset mid-transfer discards the held word with no ack.
- Effective request: eff_req = req_in & ~ack_out. This masks a channel during its ack cycle, because the channel drops req the cycle after ack.
- Winner w: first set bit of eff_req scanning (last_grant+1), (last_grant+2) … modulo 32, wrapping 31 -> 0. Combinational.
- Capture (registered at an edge):
  - data_out<=data_in[w*N +: N], sel_out<=w, valid_out<=1.
  - ack_out<=(1<<w); last_grant<=w.
- State IDLE:
  - If eff_req != 0: capture, go to HOLD.
  - Else hold outputs; valid_out=0.
- State HOLD:
  - ack_out<=0 unless a new capture happens this cycle.
  - On valid_out && ready_in with eff_req != 0: capture immediately and stay in HOLD. This gives back-to-back throughput of 1 word/cycle when multiple channels request.
  - On valid_out && ready_in with eff_req == 0: valid_out<=0, go to IDLE. data_out and sel_out keep their last value.
  - No accept: hold data_out, sel_out, valid_out unchanged.
- Latency: req_in[k] rising at edge t (state IDLE) -> valid_out and ack_out[k] high after edge t+1.
- Fairness: a continuously requesting channel waits at most 31 grants.
- Single requester re-requesting: it is granted again only after its ack cycle, because of the mask.
- ack_out never has more than one bit set.
- req_in changes during HOLD do not affect the held word.

Optional Feature:
- Macro: MUX_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter increments each cycle in HOLD with valid_out && !ready_in, and clears on accept or capture.
  - When the counter reaches TIMEOUT_CYCLES: valid_out<=0, timeout_out<=1 for one cycle, counter<=0, state<=IDLE. The word is dropped; the channel was already acked.
- Undefined:
  - No counter; timeout_out tied to 0.
  - valid_out holds indefinitely until ready_in.

Test Plan:
1. Reset, then req_in=32'h0000_0001, data ch0=16'hA5A5, ready_in=1 -> one cycle later: valid_out=1, data_out=A5A5, sel_out=0, ack_out=32'h1 for exactly 1 cycle.
2. req_in=32'hFFFF_FFFF held; each channel drops req after its ack, ready_in=1 -> sel_out sequence 0,1,2…31 on consecutive cycles, one ack per cycle, never two bits set.
3. last_grant=5, req_in bits 3 and 9 set -> grant 9 first, then 3 (wrap order).
4. ready_in=0 for 10 cycles after capture of ch7=16'h1234 while ch8 requests -> data_out=1234, sel_out=7 stable; ch8 not acked until the cycle after ready_in rises.
5. rst asserted during HOLD -> next cycle all outputs at reset values; the following grant starts from channel 0.
6. With MUX_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready_in=0 -> valid_out drops after 4 stall cycles with timeout_out pulse=1; without the macro, valid_out stays 1 and timeout_out stays 0.
